mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin select generator sitting directly upstream of gen_mux: arbitrates N requesters
//  (valid/ready), drives gen_mux.sel and forwards a valid/ready handshake to the consumer of
//  data_out. Keeps sel stable for the whole transfer so the muxed data is held under backpressure.
// PARAMETERS
//  INPUTS_NUM    3   number of requesters; must equal gen_mux INPUTS_NUM, >=2
//  MAX_BURST     4   max back-to-back transfers per grant (used only with burst macro), >=1
//  SELECT_WIDTH  $clog2(INPUTS_NUM)  localparam, do not override
// PORTS
//  clk        in   1             clock, all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  req        in   INPUTS_NUM    req[i]=1: requester i has data on gen_mux inputs_arr[i]
//  in_ready   out  INPUTS_NUM    one-hot; in_ready[i]=1: requester i's data consumed this cycle
//  sel        out  SELECT_WIDTH  to gen_mux.sel; index of granted requester
//  out_valid  out  1             data_out of gen_mux is valid
//  out_ready  in   1             downstream accepts data_out
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, sel=0, out_valid=0, in_ready=0, burst_cnt=0.
//  - All outputs registered except in_ready = onehot(sel) & {N{out_valid & out_ready}}.
//  - Transfer = out_valid & out_ready (same cycle as in_ready[sel]).
//  - FSM: IDLE -> GRANT when |req: winner = first i with req[i]=1 scanning ptr, ptr+1, ... N-1,
//    0, ... ptr-1 (mod INPUTS_NUM); sel<=winner, out_valid<=1 next cycle. Latency req->out_valid 1.
//  - GRANT: sel constant, out_valid=1 until transfer or withdrawal.
//    On transfer (no burst continuation): ptr<=(sel==INPUTS_NUM-1)?0:sel+1, out_valid<=0,
//    -> IDLE. One bubble cycle between grants; max throughput 1 transfer / 2 cycles.
//    Withdrawal: req[sel]=0 with no transfer -> IDLE, out_valid<=0, ptr unchanged.
//  - Requesters hold req and data stable until in_ready; out_valid must not drop under
//    backpressure except by withdrawal.
//  - Boundaries: sel never exceeds INPUTS_NUM-1 (non-power-of-2 N); ptr wraps N-1 -> 0;
//    req=0 in IDLE -> stay IDLE; new req arriving during GRANT waits for next arbitration;
//    rst mid-transfer: abort, no in_ready that cycle, all state to reset values.
// CONFIGURATION
//  Macro MUX_RR_ARB_BURST_EN:
//  - Defined: on transfer, if req[sel] still 1 and burst_cnt<MAX_BURST-1, stay GRANT,
//    burst_cnt++, out_valid stays 1 (no bubble, back-to-back transfers). Else release as
//    normal, burst_cnt<=0. burst_cnt width $clog2(MAX_BURST)+1; MAX_BURST=1 == no burst.
//  - Not defined: burst_cnt absent; every transfer releases the grant; MAX_BURST ignored.
// TESTING
//  1 Reset: rst=1 two cycles with req=3'b111 -> out_valid=0, sel=0, in_ready=0; rst=0 ->
//    out_valid=1 next cycle, sel=0.
//  2 Fairness: req=3'b111 held, out_ready=1 -> grant order sel 0,1,2,0,... one transfer every
//    2 cycles; in_ready one-hot matching sel each transfer.
//  3 Backpressure: req=3'b010, out_ready=0 for 5 cycles -> out_valid=1, sel=1, in_ready=0
//    stable; out_ready=1 -> in_ready=3'b010 one cycle, then out_valid=0.
//  4 Wrap/skip: after grant to 2, req=3'b001 -> sel=0; ptr=1, req=3'b100 -> sel=2.
//  5 Withdrawal/reset mid-op: in GRANT sel=1, drop req[1] -> out_valid=0 next cycle, next
//    grant still scans from ptr; assert rst during GRANT -> outputs at reset values next cycle.
//  6 Burst (macro defined, MAX_BURST=4): req=3'b011, out_ready=1 -> four back-to-back
//    transfers sel=0, bubble, then sel=1 x4; without macro -> alternating 0,1 with bubbles.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin select generator placed directly upstream of gen_mux. It
// arbitrates INPUTS_NUM requesters, drives gen_mux.sel and presents a
// valid/ready handshake for gen_mux data_out. sel is held for the whole
// transfer so the muxed data stays stable under backpressure.
//
// Optional feature macro: MUX_RR_ARB_BURST_EN
//   defined     : a grant may carry up to MAX_BURST back-to-back transfers
//   not defined : every transfer releases the grant (one bubble between grants)
//
// Parameters
//   INPUTS_NUM    number of requesters (>= 2), equals gen_mux INPUTS_NUM
//   MAX_BURST     max transfers per grant with the burst macro (>= 1)
//   SELECT_WIDTH  derived, do not override
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   req        in   [INPUTS_NUM-1:0]   requester i has data on gen_mux input i
//   in_ready   out  [INPUTS_NUM-1:0]   one-hot, requester's data consumed this cycle
//   sel        out  [SELECT_WIDTH-1:0] index of the granted requester
//   out_valid  out  data_out of gen_mux is valid
//   out_ready  in   downstream accepts data_out
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int INPUTS_NUM   = 3,
    parameter int MAX_BURST    = 4,
    localparam int SELECT_WIDTH = $clog2(INPUTS_NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUTS_NUM-1:0]   req,
    output logic [INPUTS_NUM-1:0]   in_ready,
    output logic [SELECT_WIDTH-1:0] sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned N = INPUTS_NUM;

    if (INPUTS_NUM < 2 || MAX_BURST < 1) begin : g_bad_config
        $error("mux_rr_arbiter: INPUTS_NUM must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                  state, state_nxt;
    logic [SELECT_WIDTH-1:0] ptr, ptr_nxt;
    logic [SELECT_WIDTH-1:0] sel_nxt;
    logic                    out_valid_nxt;
    logic [SELECT_WIDTH-1:0] winner;
    logic                    found;
    logic [SELECT_WIDTH-1:0] sel_inc;
    logic                    xfer;
    logic                    keep_grant;
    int unsigned             idx;

`ifdef MUX_RR_ARB_BURST_EN
    localparam int BCW = $clog2(MAX_BURST) + 1;
    logic [BCW-1:0] burst_cnt, burst_cnt_nxt;
`endif

    assign xfer = out_valid & out_ready;

    // Reset aborts a pending transfer, so the consume strobe is masked by rst.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = xfer & ~rst & (sel == SELECT_WIDTH'(i));
        end
    end

    // Scan ptr, ptr+1, ..., wrapping at N-1; first requester found wins.
    // idx is kept below N, so its low bits never address beyond req.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[SELECT_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = idx[SELECT_WIDTH-1:0];
            end
        end
    end

    // Explicit compare keeps the pointer inside 0..N-1 for non-power-of-2 N.
    assign sel_inc = (sel == SELECT_WIDTH'(N - 1)) ? '0 : sel + SELECT_WIDTH'(1);

`ifdef MUX_RR_ARB_BURST_EN
    assign keep_grant = req[sel] && (burst_cnt < BCW'(MAX_BURST - 1));
`else
    assign keep_grant = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        sel_nxt       = sel;
        out_valid_nxt = out_valid;
`ifdef MUX_RR_ARB_BURST_EN
        burst_cnt_nxt = burst_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt     = GRANT;
                    sel_nxt       = winner;
                    out_valid_nxt = 1'b1;
`ifdef MUX_RR_ARB_BURST_EN
                    burst_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (keep_grant) begin
`ifdef MUX_RR_ARB_BURST_EN
                        burst_cnt_nxt = burst_cnt + BCW'(1);
`endif
                    end else begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                        ptr_nxt       = sel_inc;
`ifdef MUX_RR_ARB_BURST_EN
                        burst_cnt_nxt = '0;
`endif
                    end
                end else if (!req[sel]) begin
                    // Withdrawal: give up the grant without moving the pointer.
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
`ifdef MUX_RR_ARB_BURST_EN
                    burst_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
`ifdef MUX_RR_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            out_valid <= out_valid_nxt;
`ifdef MUX_RR_ARB_BURST_EN
            burst_cnt <= burst_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed self-checking bench for mux_rr_arbiter (INPUTS_NUM=3, MAX_BURST=4).
// Inputs change #1 after a rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] in_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;

    int compared;
    int mismatched;

    mux_rr_arbiter #(
        .INPUTS_NUM (3),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] exp_sel);
        logic [2:0] oh;
        oh = 3'b001 << exp_sel;
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_inrdy"}, 32'(in_ready), 32'(oh & {3{out_ready}}));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    endtask

    logic [1:0] fair_sel [4];
    logic       bst_ov   [10];
    logic [1:0] bst_sel  [10];

    initial begin
        compared   = 0;
        mismatched = 0;
        fair_sel   = '{2'd0, 2'd1, 2'd2, 2'd0};
`ifdef MUX_RR_ARB_BURST_EN
        bst_ov  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bst_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
        bst_ov  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bst_sel = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
`endif

        // Reset with all requesters active
        rst       = 1'b1;
        req       = 3'b111;
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_inrdy", 32'(in_ready), 32'd0);

        rst = 1'b0;
        cyc();
        chk_grant("first", 2'd0);

        // Fairness: grants 0,1,2,0 with one bubble after each transfer
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_grant("fair", fair_sel[i]);
            cyc();
            chk_idle("fair_bubble");
            if (i < 3) cyc();
        end
        // ptr is now 1

        // Backpressure on requester 1
        req       = 3'b010;
        out_ready = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk_grant("bp_hold", 2'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_inrdy", 32'(in_ready), 32'h2);
        cyc();
        chk_idle("bp_release");
        // ptr is now 2

        // Wrap/skip: ptr=2, only req[0] -> scan wraps to 0
        req = 3'b001;
        cyc();
        chk_grant("wrap_0", 2'd0);
        cyc();
        chk_idle("wrap_0_bubble");
        // ptr=1, only req[2]
        req = 3'b100;
        cyc();
        chk_grant("skip_2", 2'd2);
        cyc();
        chk_idle("skip_2_bubble");
        // ptr wrapped 2 -> 0
        req = 3'b111;
        cyc();
        chk_grant("ptr_wrap", 2'd0);
        cyc();
        chk_idle("ptr_wrap_bubble");
        // ptr is now 1

        // Withdrawal while granted to 1
        out_ready = 1'b0;
        cyc();
        chk_grant("wd_grant", 2'd1);
        req = 3'b101;
        cyc();
        chk_idle("wd_drop");
        req = 3'b000;
        cyc();
        chk_idle("no_req");
        // ptr still 1: requester 1 wins over 0
        req = 3'b011;
        cyc();
        chk_grant("wd_ptr_kept", 2'd1);

        // Reset mid-transfer
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        chk("rst_mid_inrdy", 32'(in_ready), 32'd0);
        cyc();
        chk("rst_mid_ov", 32'(out_valid), 32'd0);
        chk("rst_mid_sel", 32'(sel), 32'd0);
        chk("rst_mid_inrdy2", 32'(in_ready), 32'd0);
        rst = 1'b0;
        cyc();
        chk_grant("post_rst", 2'd0);

        // Two active requesters, downstream always ready
        for (int j = 0; j < 10; j++) begin
            if (bst_ov[j]) begin
                chk_grant("burst", bst_sel[j]);
            end else begin
                chk_idle("burst_bubble");
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
